// File: rtl/gsensor_pkg.sv
// Shared definitions for the ADXL345 command sequencer.
// Contents: the sequencer state enum, ADXL345 register addresses, the
// power-up init table (as a lookup function) and the periodic read command.
package gsensor_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StLoad,
    StXfer,
    StGap,
    StWait,
    StPublish
  } state_e;

  // ADXL345 register addresses (6-bit SPI address field)
  localparam logic [5:0] AdxlBwRate     = 6'h2C;
  localparam logic [5:0] AdxlPowerCtl   = 6'h2D;
  localparam logic [5:0] AdxlIntEnable  = 6'h2E;
  localparam logic [5:0] AdxlDataFormat = 6'h31;
  localparam logic [5:0] AdxlDatax0     = 6'h32;

  localparam int unsigned INIT_LEN   = 4;
  localparam int unsigned FrameBytes = 6;

  // Command word layout: {R/W, MB, addr[5:0], wdata[7:0]}
  localparam logic [15:0] READ_CMD = {2'b11, AdxlDatax0, 8'h00};

  // Init writes, issued in index order; all single-byte writes.
  function automatic logic [15:0] init_cmd(input logic [1:0] idx);
    logic [15:0] cmd;
    unique case (idx)
      2'd0: cmd = {2'b00, AdxlDataFormat, 8'h40};  // 3-wire SPI, +/-2g
      2'd1: cmd = {2'b00, AdxlBwRate,     8'h09};  // 50 Hz output rate
      2'd2: cmd = {2'b00, AdxlIntEnable,  8'h00};  // no interrupts
      2'd3: cmd = {2'b00, AdxlPowerCtl,   8'h08};  // measure mode
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/gsensor_frame_asm.sv
// Read-frame byte collector.
// Stores up to six received bytes in arrival order and presents them as
// little-endian signed 16-bit X/Y/Z words.
// Ports:
//   iSPI_CLK, iRst_n : clock, asynchronous active-low reset
//   clr_i            : clear the byte count (start of a new command)
//   capture_i        : one-cycle strobe, store data_i at the current count
//   data_i           : received byte
//   cnt_o            : bytes stored so far, saturates at six
//   overflow_o       : capture attempted with six bytes already stored
//   x_o, y_o, z_o    : assembled samples
module gsensor_frame_asm
  import gsensor_pkg::*;
#(
  parameter int unsigned SO_DataL = 8
) (
  input  logic                iSPI_CLK,
  input  logic                iRst_n,
  input  logic                clr_i,
  input  logic                capture_i,
  input  logic [SO_DataL-1:0] data_i,
  output logic [2:0]          cnt_o,
  output logic                overflow_o,
  output logic [15:0]         x_o,
  output logic [15:0]         y_o,
  output logic [15:0]         z_o
);

  localparam logic [2:0] CntFull = 3'(FrameBytes);

  logic [7:0] byte_q [FrameBytes];
  logic [2:0] cnt_q;

  always_ff @(posedge iSPI_CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < FrameBytes; i++) begin
        byte_q[i] <= '0;
      end
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (capture_i && (cnt_q < CntFull)) begin
      byte_q[cnt_q] <= data_i[7:0];
      cnt_q         <= cnt_q + 3'd1;
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = capture_i && (cnt_q == CntFull);

  assign x_o = {byte_q[1], byte_q[0]};
  assign y_o = {byte_q[3], byte_q[2]};
  assign z_o = {byte_q[5], byte_q[4]};

endmodule

// File: rtl/gsensor_sequencer.sv
// ADXL345 command sequencer feeding the 3-wire SPI controller.
// After reset it waits PWRUP_CYCLES, writes the init table, then issues a
// 6-byte burst read of DATAX0..DATAZ1 every SAMPLE_CYCLES and publishes the
// assembled X/Y/Z samples with a one-cycle strobe.
// Ports:
//   iSPI_CLK, iRst_n     : clock, asynchronous active-low reset
//   iSPI_END             : controller end-of-transfer
//   iS2P_DATA, iS2P_Dval : controller read byte and its valid level
//   oP2S_DATA            : command word {R/W, MB, addr, wdata}
//   oSPI_GO              : transfer request / chip select
//   oMultiBytes          : multi-byte enable, mirrors oP2S_DATA[14]
//   oX, oY, oZ, oDval    : latest samples and their update strobe
//   oInitDone            : init table completed
//   oFrameErr            : sticky, a read returned other than six bytes
module gsensor_sequencer
  import gsensor_pkg::*;
#(
  parameter int unsigned SI_DataL      = 16,
  parameter int unsigned SO_DataL      = 8,
  parameter int unsigned PWRUP_CYCLES  = 1024,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned SAMPLE_CYCLES = 4096
) (
  input  logic                iSPI_CLK,
  input  logic                iRst_n,
  input  logic                iSPI_END,
  input  logic [SO_DataL-1:0] iS2P_DATA,
  input  logic                iS2P_Dval,
  output logic [SI_DataL-1:0] oP2S_DATA,
  output logic                oSPI_GO,
  output logic                oMultiBytes,
  output logic [15:0]         oX,
  output logic [15:0]         oY,
  output logic [15:0]         oZ,
  output logic                oDval,
  output logic                oInitDone,
  output logic                oFrameErr
);

  localparam int unsigned PwrW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int unsigned TmrW = $clog2(SAMPLE_CYCLES);

  localparam logic [PwrW-1:0] PwrLast = PwrW'(PWRUP_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]      GapLast = 8'(GAP_CYCLES - 1);
  localparam logic [2:0]      CntFull = 3'(FrameBytes);

  state_e              state_q, state_d;
  logic [PwrW-1:0]     pwr_cnt_q, pwr_cnt_d;
  logic [7:0]          gap_cnt_q, gap_cnt_d;
  logic                xfer_seen_q, xfer_seen_d;
  logic [1:0]          idx_q, idx_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [SI_DataL-1:0] p2s_q, p2s_d;
  logic                is_read_q, is_read_d;
  logic                init_done_q, init_done_d;
  logic                frame_err_q, frame_err_d;
  logic                dval_q, dval_d;
  logic [15:0]         x_q, x_d, y_q, y_d, z_q, z_d;
  logic                dval_prev_q;

  logic        frame_clr;
  logic        capture;
  logic [2:0]  frame_cnt;
  logic        frame_ovf;
  logic [15:0] asm_x, asm_y, asm_z;

  // Rising edge of the controller's byte-valid, only while a read is in flight
  assign capture = (state_q == StXfer) && is_read_q && iS2P_Dval && !dval_prev_q;

  gsensor_frame_asm #(
    .SO_DataL (SO_DataL)
  ) u_frame_asm (
    .iSPI_CLK   (iSPI_CLK),
    .iRst_n     (iRst_n),
    .clr_i      (frame_clr),
    .capture_i  (capture),
    .data_i     (iS2P_DATA),
    .cnt_o      (frame_cnt),
    .overflow_o (frame_ovf),
    .x_o        (asm_x),
    .y_o        (asm_y),
    .z_o        (asm_z)
  );

  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    xfer_seen_d = xfer_seen_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    p2s_d       = p2s_q;
    is_read_d   = is_read_q;
    init_done_d = init_done_q;
    frame_err_d = frame_err_q;
    dval_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    frame_clr   = 1'b0;

    // Sample timer free-runs once init is done and parks at zero when expired
    if (init_done_q && (tmr_q != '0)) begin
      tmr_d = tmr_q - TmrW'(1);
    end

    if (frame_ovf) begin
      frame_err_d = 1'b1;
    end

    unique case (state_q)
      StPwrup: begin
        if (pwr_cnt_q == PwrLast) begin
          state_d = StLoad;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PwrW'(1);
        end
      end
      StLoad: begin
        frame_clr   = 1'b1;
        xfer_seen_d = 1'b0;
        is_read_d   = init_done_q;
        p2s_d       = init_done_q ? SI_DataL'(READ_CMD) : SI_DataL'(init_cmd(idx_q));
        state_d     = StXfer;
      end
      StXfer: begin
        xfer_seen_d = 1'b1;
        // END is still high from idle on the first GO cycle; ignore it there
        if (iSPI_END && xfer_seen_q) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          if (!init_done_q) begin
            if (idx_q == 2'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
              state_d     = StWait;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = StLoad;
            end
          end else if (is_read_q) begin
            state_d = StPublish;
          end else begin
            state_d = StWait;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      StWait: begin
        // Reload on the way into the read LOAD so start-to-start is exact
        if (tmr_q == '0) begin
          tmr_d   = TmrLoad;
          state_d = StLoad;
        end
      end
      StPublish: begin
        if (frame_cnt == CntFull) begin
          x_d    = asm_x;
          y_d    = asm_y;
          z_d    = asm_z;
          dval_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = StWait;
      end
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge iSPI_CLK or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= StPwrup;
      pwr_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      xfer_seen_q <= 1'b0;
      idx_q       <= '0;
      tmr_q       <= '0;
      p2s_q       <= '0;
      is_read_q   <= 1'b0;
      init_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      dval_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      dval_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      xfer_seen_q <= xfer_seen_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      p2s_q       <= p2s_d;
      is_read_q   <= is_read_d;
      init_done_q <= init_done_d;
      frame_err_q <= frame_err_d;
      dval_q      <= dval_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      dval_prev_q <= iS2P_Dval;
    end
  end

  // GO follows the state register directly so reset drops it without a clock
  assign oSPI_GO     = (state_q == StXfer);
  assign oP2S_DATA   = p2s_q;
  assign oMultiBytes = p2s_q[14];
  assign oX          = x_q;
  assign oY          = y_q;
  assign oZ          = z_q;
  assign oDval       = dval_q;
  assign oInitDone   = init_done_q;
  assign oFrameErr   = frame_err_q;

endmodule
